psum_acc_out: RTL and testbench

PSUM_ACC_OUT -- requirements
Module: psum_acc_out

---
 rtl/psum_acc_out.sv | 124 ++++++++++++
 tb/tb_psum_acc_out.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/psum_acc_out.sv
// psum_acc_out: accumulates a configurable number of PE_vec partial sums onto
// a bias, then rounds, optionally ReLU-clamps, saturates and presents one
// quantized output activation behind a valid/ready handshake.

`ifndef PSUM_WID
`define PSUM_WID 16
`endif

module psum_acc_out #(
  parameter int PSUM_W = `PSUM_WID,
  parameter int ACC_W  = 32,
  parameter int OUT_W  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [3:0]               cfg_passes,
  input  logic [4:0]               cfg_shift,
  input  logic                     cfg_relu,
  input  logic signed [ACC_W-1:0]  bias,
  input  logic                     psum_valid,
  input  logic signed [PSUM_W-1:0] psum,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [OUT_W-1:0]  out_data,
  output logic                     busy,
  output logic                     done
);

  typedef enum logic [1:0] {IDLE, ACC, ROUND, OUT} state_t;

  // Saturation bounds expressed at the widened rounding width so the
  // comparisons below are plain signed compares.
  localparam logic signed [ACC_W:0] OUT_MAX = (ACC_W+1)'((2 ** (OUT_W - 1)) - 1);
  localparam logic signed [ACC_W:0] OUT_MIN = -OUT_MAX - (ACC_W+1)'(1);

  state_t                    state;
  logic signed [ACC_W-1:0]   acc;
  logic [3:0]                cnt;
  logic [3:0]                passes;
  logic [4:0]                shift;
  logic                      relu;

  logic signed [ACC_W-1:0]   psum_ext;
  logic signed [ACC_W:0]     acc_ext;
  logic signed [ACC_W:0]     half;
  logic signed [ACC_W:0]     rsum;
  logic signed [ACC_W:0]     rshift;
  logic signed [ACC_W:0]     rclip;
  logic signed [ACC_W:0]     rsat;
  logic signed [OUT_W-1:0]   quant;

  assign psum_ext = {{(ACC_W - PSUM_W){psum[PSUM_W-1]}}, psum};

  // Requantize the finished accumulator: round half up, shift, ReLU, saturate.
  // One extra bit of headroom keeps acc + 2^(shift-1) from overflowing.
  always_comb begin
    // NOTE: every signal gets a value before any condition so no latch is inferred.
    half    = '0;
    acc_ext = {acc[ACC_W-1], acc};
    if (shift != 5'd0) half = (ACC_W+1)'(1) << (shift - 5'd1);
    rsum    = acc_ext + half;
    rshift  = rsum >>> shift;
    rclip   = (relu && rshift[ACC_W]) ? '0 : rshift;
    if (rclip > OUT_MAX)      rsat = OUT_MAX;
    else if (rclip < OUT_MIN) rsat = OUT_MIN;
    else                      rsat = rclip;
    quant   = rsat[OUT_W-1:0];
  end

  // Control FSM with all outputs registered alongside the state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      passes    <= 4'd1;
      shift     <= '0;
      relu      <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            passes <= (cfg_passes == 4'd0) ? 4'd1 : cfg_passes;
            shift  <= cfg_shift;
            relu   <= cfg_relu;
            acc    <= bias;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= ACC;
          end
        end
        ACC: begin
          if (psum_valid) begin
            acc <= acc + psum_ext;
            cnt <= cnt + 4'd1;
            if (cnt == passes - 4'd1) state <= ROUND;
          end
        end
        ROUND: begin
          out_data  <= quant;
          out_valid <= 1'b1;
          state     <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            done      <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_psum_acc_out.sv
// Directed bench for psum_acc_out: basic accumulation, saturation, rounding,
// ReLU, back-pressure, ignored inputs, mid-pixel reset and back-to-back pixels.

module tb_psum_acc_out;

  localparam int PSUM_W = 16;
  localparam int ACC_W  = 32;
  localparam int OUT_W  = 8;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     start;
  logic [3:0]               cfg_passes;
  logic [4:0]               cfg_shift;
  logic                     cfg_relu;
  logic signed [ACC_W-1:0]  bias;
  logic                     psum_valid;
  logic signed [PSUM_W-1:0] psum;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [OUT_W-1:0]  out_data;
  logic                     busy;
  logic                     done;

  int n_pass = 0;
  int n_tot  = 0;

  psum_acc_out #(.PSUM_W(PSUM_W), .ACC_W(ACC_W), .OUT_W(OUT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_passes(cfg_passes),
    .cfg_shift(cfg_shift), .cfg_relu(cfg_relu), .bias(bias),
    .psum_valid(psum_valid), .psum(psum), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle; drive and sample happen here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse start, then scramble the cfg inputs to prove they were latched.
  task automatic start_pixel(input logic signed [ACC_W-1:0] b, input logic [3:0] p,
                             input logic [4:0] s, input logic r);
    start = 1'b1; bias = b; cfg_passes = p; cfg_shift = s; cfg_relu = r;
    tick();
    start = 1'b0; bias = 32'sd77; cfg_passes = 4'd9; cfg_shift = 5'd7; cfg_relu = ~r;
  endtask

  task automatic send_psum(input logic signed [PSUM_W-1:0] v);
    psum_valid = 1'b1; psum = v;
    tick();
    psum_valid = 1'b0; psum = 16'sh1234;
  endtask

  // Run a one-psum pixel through ROUND into OUT.
  task automatic one_pass(input logic signed [ACC_W-1:0] b, input logic signed [PSUM_W-1:0] v,
                          input logic [4:0] s, input logic r);
    start_pixel(b, 4'd1, s, r);
    send_psum(v);
    tick();
  endtask

  // Complete the handshake; leaves the bench one settle after the edge.
  task automatic handshake();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick();
    n_tot++; if ({out_valid, busy, done} !== 3'b000)
      $display("FAIL reset_flags got=%b exp=000", {out_valid, busy, done}); else n_pass++;
    n_tot++; if (out_data !== 8'sd0)
      $display("FAIL reset_data got=%0d exp=0", out_data); else n_pass++;
    rst = 1'b1;
    start_pixel(32'sd0, 4'd3, 5'd0, 1'b0);
    n_tot++; if (busy !== 1'b1)
      $display("FAIL first_start_busy got=%b exp=1", busy); else n_pass++;
  endtask

  // bias 0, psums 10,20,-5 -> 25; two cycles from last psum to out_valid.
  task automatic test_basic();
    int dones;
    send_psum(16'sd10);
    send_psum(16'sd20);
    send_psum(-16'sd5);
    n_tot++; if (out_valid !== 1'b0)
      $display("FAIL basic_round_valid got=%b exp=0", out_valid); else n_pass++;
    tick();
    n_tot++; if (out_valid !== 1'b1)
      $display("FAIL basic_latency_valid got=%b exp=1", out_valid); else n_pass++;
    n_tot++; if (out_data !== 8'sd25)
      $display("FAIL basic_data got=%0d exp=25", out_data); else n_pass++;
    handshake();
    dones = 0;
    if (done === 1'b1) dones++;
    n_tot++; if ({out_valid, busy} !== 2'b00)
      $display("FAIL basic_post_hs got=%b exp=00", {out_valid, busy}); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (done === 1'b1) dones++;
    end
    n_tot++; if (dones !== 1)
      $display("FAIL basic_done_count got=%0d exp=1", dones); else n_pass++;
  endtask

  task automatic test_saturate();
    start_pixel(32'sd100, 4'd2, 5'd0, 1'b0);
    send_psum(16'sd150);
    send_psum(16'sd50);
    tick();
    n_tot++; if (out_data !== 8'sd127)
      $display("FAIL sat_pos got=%0d exp=127", out_data); else n_pass++;
    handshake();
    start_pixel(32'sd0, 4'd2, 5'd0, 1'b0);
    send_psum(-16'sd200);
    send_psum(-16'sd100);
    tick();
    n_tot++; if (out_data !== -8'sd128)
      $display("FAIL sat_neg got=%0d exp=-128", out_data); else n_pass++;
    handshake();
  endtask

  task automatic test_round();
    one_pass(32'sd7, 16'sd0, 5'd1, 1'b0);
    n_tot++; if (out_data !== 8'sd4)
      $display("FAIL round_pos got=%0d exp=4", out_data); else n_pass++;
    handshake();
    one_pass(-32'sd7, 16'sd0, 5'd1, 1'b0);
    n_tot++; if (out_data !== -8'sd3)
      $display("FAIL round_neg got=%0d exp=-3", out_data); else n_pass++;
    handshake();
    one_pass(32'sd0, -16'sd40, 5'd0, 1'b1);
    n_tot++; if (out_data !== 8'sd0)
      $display("FAIL relu_clamp got=%0d exp=0", out_data); else n_pass++;
    handshake();
    one_pass(32'sd0, 16'sd102, 5'd2, 1'b0);
    n_tot++; if (out_data !== 8'sd26)
      $display("FAIL round_shift2 got=%0d exp=26", out_data); else n_pass++;
    handshake();
    one_pass(-32'sd12, 16'sd0, 5'd3, 1'b1);
    n_tot++; if (out_data !== 8'sd0)
      $display("FAIL relu_after_round got=%0d exp=0", out_data); else n_pass++;
    handshake();
    one_pass(32'sd1000, -16'sd20, 5'd4, 1'b0);
    n_tot++; if (out_data !== 8'sd61)
      $display("FAIL round_shift4 got=%0d exp=61", out_data); else n_pass++;
    handshake();
  endtask

  task automatic test_stall();
    one_pass(32'sd0, -16'sd33, 5'd0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      n_tot++; if ({out_valid, done} !== 2'b10 || out_data !== -8'sd33)
        $display("FAIL stall_hold cyc=%0d got v=%b d=%b data=%0d exp v=1 d=0 data=-33",
                 i, out_valid, done, out_data); else n_pass++;
    end
    handshake();
    n_tot++; if (done !== 1'b1)
      $display("FAIL stall_done got=%b exp=1", done); else n_pass++;
    tick();
    n_tot++; if (done !== 1'b0)
      $display("FAIL stall_done_pulse got=%b exp=0", done); else n_pass++;
  endtask

  task automatic test_ignored_inputs();
    send_psum(16'sd33);
    n_tot++; if (busy !== 1'b0)
      $display("FAIL idle_psum_busy got=%b exp=0", busy); else n_pass++;
    start_pixel(32'sd0, 4'd0, 5'd0, 1'b0);
    start = 1'b1; bias = 32'sd999; cfg_passes = 4'd3;
    tick();
    start = 1'b0;
    send_psum(16'sd5);
    n_tot++; if ({busy, out_valid} !== 2'b10)
      $display("FAIL passes0_round got=%b exp=10", {busy, out_valid}); else n_pass++;
    send_psum(16'sd7);
    send_psum(16'sd9);
    n_tot++; if (out_valid !== 1'b1 || out_data !== 8'sd5)
      $display("FAIL ignored_data got v=%b data=%0d exp v=1 data=5", out_valid, out_data);
    else n_pass++;
    handshake();
    n_tot++; if (done !== 1'b1)
      $display("FAIL ignored_done got=%b exp=1", done); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int dones;
    start_pixel(32'sd0, 4'd3, 5'd0, 1'b0);
    send_psum(16'sd50);
    #2 rst = 1'b0;
    #1;
    n_tot++; if ({out_valid, busy, done} !== 3'b000 || out_data !== 8'sd0)
      $display("FAIL rst_mid_acc got flags=%b data=%0d exp flags=000 data=0",
               {out_valid, busy, done}, out_data); else n_pass++;
    tick();
    rst = 1'b1;
    start_pixel(32'sd0, 4'd3, 5'd0, 1'b0);
    send_psum(16'sd1);
    send_psum(16'sd2);
    send_psum(16'sd3);
    tick();
    n_tot++; if (out_data !== 8'sd6)
      $display("FAIL rst_no_stale got=%0d exp=6", out_data); else n_pass++;
    #2 rst = 1'b0;
    #1;
    n_tot++; if (out_valid !== 1'b0)
      $display("FAIL rst_mid_out got=%b exp=0", out_valid); else n_pass++;
    tick();
    rst = 1'b1;
    out_ready = 1'b1;
    dones = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (done === 1'b1) dones++;
    end
    out_ready = 1'b0;
    n_tot++; if (dones !== 0)
      $display("FAIL rst_no_done got=%0d exp=0", dones); else n_pass++;
  endtask

  task automatic test_back_to_back();
    one_pass(32'sd20, 16'sd1, 5'd0, 1'b0);
    handshake();
    start = 1'b1; bias = -32'sd3; cfg_passes = 4'd1; cfg_shift = 5'd0; cfg_relu = 1'b0;
    tick();
    start = 1'b0;
    n_tot++; if ({busy, done} !== 2'b10)
      $display("FAIL b2b_start got=%b exp=10", {busy, done}); else n_pass++;
    send_psum(-16'sd4);
    tick();
    n_tot++; if (out_data !== -8'sd7)
      $display("FAIL b2b_data got=%0d exp=-7", out_data); else n_pass++;
    handshake();
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; cfg_passes = '0; cfg_shift = '0; cfg_relu = 1'b0;
    bias = '0; psum_valid = 1'b0; psum = '0; out_ready = 1'b0;
    test_reset();
    test_basic();
    test_saturate();
    test_round();
    test_stall();
    test_ignored_inputs();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "bench did not complete");
  end

endmodule
